conv_addr_sequencer: RTL and testbench
======================================

CONV_ADDR_SEQUENCER -- requirements
Module: conv_addr_sequencer

Interface
REQ-001 The block SHALL have parameter IN_AW, default 8, meaning input-memory address width (256 words).
REQ-002 The block SHALL have parameter K_AW, default 6, meaning kernel-memory address width (64 words).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, meaning a one-cycle request to begin a convolution.
REQ-006 The block SHALL have port img_w, input, 8, meaning input width in elements.
REQ-007 The block SHALL have port img_h, input, 8, meaning input height in elements.
REQ-008 The block SHALL have port k_w, input, 4, meaning kernel width.
REQ-009 The block SHALL have port k_h, input, 4, meaning kernel height.
REQ-010 The block SHALL have port stall, input, 1, meaning downstream backpressure (FIFO nearly full).
REQ-011 The block SHALL have port rd_en, output, 1, meaning a read strobe to both memories.
REQ-012 The block SHALL have port rd_add_in, output, IN_AW, meaning the input-memory read address.
REQ-013 The block SHALL have port rd_add_k, output, K_AW, meaning the kernel-memory read address.
REQ-014 The block SHALL have port last_tap, output, 1, meaning the current read is the final tap of a window.
REQ-015 The block SHALL have port out_size, output, 9, meaning the output element count OW*OH.
REQ-016 The block SHALL have port size_valid, output, 1, meaning out_size is valid.
REQ-017 The block SHALL have ports busy, done and cfg_err, output, 1 each, meaning running, one-cycle completion pulse and one-cycle rejected-configuration pulse.

Function
REQ-018 The FSM SHALL have states IDLE, CHECK, RUN and FIN; it SHALL leave IDLE only on start=1, and it SHALL ignore start in every other state.
REQ-019 On start in IDLE, the block SHALL latch img_w, img_h, k_w and k_h and go to CHECK.
REQ-020 CHECK SHALL reject the configuration (pulse cfg_err for one cycle, return to IDLE, issue no reads) if any of these holds: k_w=0, k_h=0, img_w=0, img_h=0, k_w>img_w, k_h>img_h, img_w*img_h>256, or k_w*k_h>64.
REQ-021 Otherwise CHECK SHALL register OW=img_w-k_w+1, OH=img_h-k_h+1 and out_size=OW*OH (9-bit, no truncation), assert size_valid from the next cycle until the next start, and enter RUN.
REQ-022 In RUN, counters kx (fastest), ky, ox and oy (slowest) SHALL advance one step per cycle in which stall=0.
REQ-023 rd_add_in SHALL equal (oy+ky)*img_w + (ox+kx), rd_add_k SHALL equal ky*k_w + kx, and both SHALL be registered and presented together with rd_en=1.
REQ-024 When stall=1, rd_en SHALL be 0 and the counters and address outputs SHALL hold; a stall that rises and falls SHALL lose and duplicate no taps.
REQ-025 last_tap SHALL be 1 with the read at kx=k_w-1 and ky=k_h-1.
REQ-026 After the last tap of window (OW-1, OH-1), the FSM SHALL enter FIN and pulse done for one cycle, with busy=0 in that same cycle, then return to IDLE.
REQ-027 Latency SHALL be: start at cycle t gives the first rd_en at t+2; with no stalls, RUN SHALL issue exactly out_size*k_w*k_h reads on consecutive cycles.
REQ-028 busy SHALL be 1 in CHECK and RUN.

Reset
REQ-029 While rst=1, all outputs SHALL be 0, the state SHALL be IDLE and the counters SHALL be 0; a reset during RUN SHALL abort without done.

Structure
REQ-030 The state encoding and the IN_AW/K_AW limits (256, 64) SHALL be defined in shared package conv_pkg.
REQ-031 The four-level nested counter SHALL be implemented as a single sub-module conv_window_counter (enable, limits, wrap flags).

Verification
REQ-032 The bench SHALL drive a 4x4 image with a 3x3 kernel and require: out_size=4, 36 reads, first window rd_add_in=0,1,2,4,5,6,8,9,10 with rd_add_k=0..8, last rd_add_in=15, and 4 last_tap pulses.
REQ-033 The bench SHALL drive a 16x16 image with a 1x1 kernel and require: out_size=256, 256 reads at rd_add_in=0..255, rd_add_k always 0, and last_tap on every read.
REQ-034 The bench SHALL drive the 4x4/3x3 case with stall held for 3 cycles at read 10 and require: the read sequence is identical to the unstalled case and done arrives 3 cycles later.
REQ-035 The bench SHALL drive img_w=4 with k_w=5, and separately k_w=k_h=9, and require: a cfg_err pulse, no rd_en, and size_valid=0.
REQ-036 The bench SHALL assert rst at read 20 of the 4x4/3x3 case and require: all outputs 0 immediately (asynchronously), no done, and a new start afterwards running cleanly.
REQ-037 The bench SHALL pulse start during RUN and require: it is ignored, and the read count and out_size are unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution address sequencer: FSM encoding,
// default address widths and the memory depth limits used by the
// configuration check.
package conv_pkg;

   localparam int IN_AW_DEF = 8;
   localparam int K_AW_DEF  = 6;
   localparam int IN_WORDS  = 256;
   localparam int K_WORDS   = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RUN   = 2'd2,
      FIN   = 2'd3
   } conv_state_e;

endpackage

// File: rtl/conv_window_counter.sv
// Four-level nested counter walking a convolution: kx fastest, then ky,
// then ox, then oy. Exposes the next-state values so the parent can
// register addresses that line up with the counter they describe.
module conv_window_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic [3:0] kx_max_i,
   input  logic [3:0] ky_max_i,
   input  logic [7:0] ox_max_i,
   input  logic [7:0] oy_max_i,
   output logic [3:0] kx_nxt_o,
   output logic [3:0] ky_nxt_o,
   output logic [7:0] ox_nxt_o,
   output logic [7:0] oy_nxt_o,
   output logic       win_wrap_o
);

   logic [3:0] kx_q, kx_d, ky_q, ky_d;
   logic [7:0] ox_q, ox_d, oy_q, oy_d;
   logic       kx_wrap, ky_wrap, ox_wrap, oy_wrap;

   assign kx_wrap = (kx_q == kx_max_i);
   assign ky_wrap = (ky_q == ky_max_i);
   assign ox_wrap = (ox_q == ox_max_i);
   assign oy_wrap = (oy_q == oy_max_i);

   // Ripple-carry style advance: each level steps only when all faster levels wrap.
   always_comb begin
      kx_d = kx_q;
      ky_d = ky_q;
      ox_d = ox_q;
      oy_d = oy_q;
      if (clr_i) begin
         kx_d = '0;
         ky_d = '0;
         ox_d = '0;
         oy_d = '0;
      end else if (en_i) begin
         kx_d = kx_wrap ? 4'd0 : kx_q + 4'd1;
         if (kx_wrap) begin
            ky_d = ky_wrap ? 4'd0 : ky_q + 4'd1;
            if (ky_wrap) begin
               ox_d = ox_wrap ? 8'd0 : ox_q + 8'd1;
               if (ox_wrap) begin
                  oy_d = oy_wrap ? 8'd0 : oy_q + 8'd1;
               end
            end
         end
      end
   end

   // Counter state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kx_q <= '0;
         ky_q <= '0;
         ox_q <= '0;
         oy_q <= '0;
      end else begin
         kx_q <= kx_d;
         ky_q <= ky_d;
         ox_q <= ox_d;
         oy_q <= oy_d;
      end
   end

   assign kx_nxt_o   = kx_d;
   assign ky_nxt_o   = ky_d;
   assign ox_nxt_o   = ox_d;
   assign oy_nxt_o   = oy_d;
   assign win_wrap_o = kx_wrap & ky_wrap & ox_wrap & oy_wrap;

endmodule

// File: rtl/conv_addr_sequencer.sv
// Convolution read-address sequencer. Latches a geometry on start, checks
// it against the memory limits, then streams input/kernel read addresses
// one tap per unstalled cycle.
//
// state | meaning
// IDLE  | waiting for start; geometry latched on start
// CHECK | validate geometry, register output size, preload tap 0
// RUN   | one read per cycle while stall is low
// FIN   | one-cycle done pulse, busy low
module conv_addr_sequencer
   import conv_pkg::*;
#(
   parameter int IN_AW = IN_AW_DEF,
   parameter int K_AW  = K_AW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       img_w,
   input  logic [7:0]       img_h,
   input  logic [3:0]       k_w,
   input  logic [3:0]       k_h,
   input  logic             stall,
   output logic             rd_en,
   output logic [IN_AW-1:0] rd_add_in,
   output logic [K_AW-1:0]  rd_add_k,
   output logic             last_tap,
   output logic [8:0]       out_size,
   output logic             size_valid,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);

   conv_state_e      state_q, state_d;
   logic [7:0]       img_w_q, img_h_q, ow_q, oh_q, ow_calc, oh_calc;
   logic [3:0]       k_w_q, k_h_q, kx_max, ky_max;
   logic [7:0]       ox_max, oy_max;
   logic [15:0]      img_area;
   logic [7:0]       k_area;
   logic             cfg_bad, fire, cnt_clr, win_wrap, accept;
   logic [3:0]       kx_nxt, ky_nxt;
   logic [7:0]       ox_nxt, oy_nxt;
   logic [8:0]       out_size_q, size_calc;
   logic             size_valid_q;
   logic [IN_AW-1:0] rd_add_in_q, rd_add_in_d;
   logic [K_AW-1:0]  rd_add_k_q, rd_add_k_d;
   logic             last_tap_q, last_tap_d;

   assign accept   = (state_q == IDLE) && start;
   assign fire     = (state_q == RUN) && !stall;
   assign cnt_clr  = (state_q != RUN);

   assign img_area = {8'd0, img_w_q} * {8'd0, img_h_q};
   assign k_area   = {4'd0, k_w_q} * {4'd0, k_h_q};
   assign cfg_bad  = (k_w_q == 4'd0) || (k_h_q == 4'd0) ||
                     (img_w_q == 8'd0) || (img_h_q == 8'd0) ||
                     ({4'd0, k_w_q} > img_w_q) || ({4'd0, k_h_q} > img_h_q) ||
                     (img_area > 16'(IN_WORDS)) || (k_area > 8'(K_WORDS));

   assign ow_calc   = img_w_q - {4'd0, k_w_q} + 8'd1;
   assign oh_calc   = img_h_q - {4'd0, k_h_q} + 8'd1;
   assign size_calc = {1'b0, ow_calc} * {1'b0, oh_calc};

   assign kx_max = k_w_q - 4'd1;
   assign ky_max = k_h_q - 4'd1;
   assign ox_max = ow_q - 8'd1;
   assign oy_max = oh_q - 8'd1;

   conv_window_counter u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (cnt_clr),
      .en_i       (fire),
      .kx_max_i   (kx_max),
      .ky_max_i   (ky_max),
      .ox_max_i   (ox_max),
      .oy_max_i   (oy_max),
      .kx_nxt_o   (kx_nxt),
      .ky_nxt_o   (ky_nxt),
      .ox_nxt_o   (ox_nxt),
      .oy_nxt_o   (oy_nxt),
      .win_wrap_o (win_wrap)
   );

   // Addresses of the tap the counter will hold next cycle, so the registered
   // address always describes the tap currently waiting to be read.
   always_comb begin
      rd_add_in_d = (IN_AW'(oy_nxt) + IN_AW'(ky_nxt)) * IN_AW'(img_w_q)
                  + IN_AW'(ox_nxt) + IN_AW'(kx_nxt);
      rd_add_k_d  = K_AW'(ky_nxt) * K_AW'(k_w_q) + K_AW'(kx_nxt);
      last_tap_d  = (kx_nxt == kx_max) && (ky_nxt == ky_max);
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = CHECK;
         CHECK:   state_d = cfg_bad ? IDLE : RUN;
         RUN:     if (fire && win_wrap) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Geometry is captured once per start; later input changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         img_w_q <= '0;
         img_h_q <= '0;
         k_w_q   <= '0;
         k_h_q   <= '0;
      end else if (accept) begin
         img_w_q <= img_w;
         img_h_q <= img_h;
         k_w_q   <= k_w;
         k_h_q   <= k_h;
      end
   end

   // Output size: cleared on start, published once the geometry passes the check.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ow_q         <= '0;
         oh_q         <= '0;
         out_size_q   <= '0;
         size_valid_q <= 1'b0;
      end else if (accept) begin
         out_size_q   <= '0;
         size_valid_q <= 1'b0;
      end else if (state_q == CHECK && !cfg_bad) begin
         ow_q         <= ow_calc;
         oh_q         <= oh_calc;
         out_size_q   <= size_calc;
         size_valid_q <= 1'b1;
      end
   end

   // Address registers follow the counter; they hold whenever the counter holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_add_in_q <= '0;
         rd_add_k_q  <= '0;
         last_tap_q  <= 1'b0;
      end else begin
         rd_add_in_q <= rd_add_in_d;
         rd_add_k_q  <= rd_add_k_d;
         last_tap_q  <= last_tap_d;
      end
   end

   assign rd_en      = fire;
   assign rd_add_in  = rd_add_in_q;
   assign rd_add_k   = rd_add_k_q;
   assign last_tap   = fire & last_tap_q;
   assign out_size   = out_size_q;
   assign size_valid = size_valid_q;
   assign busy       = (state_q == CHECK) || (state_q == RUN);
   assign done       = (state_q == FIN);
   assign cfg_err    = (state_q == CHECK) && cfg_bad;

endmodule

// File: tb/tb_conv_addr_sequencer.sv
module tb_conv_addr_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stall = 1'b0;
   logic [7:0] img_w = '0, img_h = '0;
   logic [3:0] k_w = '0, k_h = '0;
   logic       rd_en, last_tap, size_valid, busy, done, cfg_err;
   logic [7:0] rd_add_in;
   logic [5:0] rd_add_k;
   logic [8:0] out_size;

   conv_addr_sequencer #(.IN_AW(8), .K_AW(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .img_w      (img_w),
      .img_h      (img_h),
      .k_w        (k_w),
      .k_h        (k_h),
      .stall      (stall),
      .rd_en      (rd_en),
      .rd_add_in  (rd_add_in),
      .rd_add_k   (rd_add_k),
      .last_tap   (last_tap),
      .out_size   (out_size),
      .size_valid (size_valid),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0] a_in;
      logic [5:0] a_k;
      logic       last;
   } exp_t;

   exp_t       exp_q[$];
   int         pass_cnt = 0;
   int         total_cnt = 0;
   int         n_reads = 0, n_last = 0, n_done = 0, n_cfgerr = 0;
   int         first_cyc = 0, done_cyc = 0, start_cyc = 0;
   logic [7:0] last_addr = '0;

   // Scoreboard side: every read the DUT presents is popped and compared.
   always @(negedge clk) begin
      exp_t got, e;
      if (rd_en === 1'b1) begin
         got = {rd_add_in, rd_add_k, last_tap};
         if (n_reads == 0) first_cyc = cyc;
         n_reads++;
         if (last_tap === 1'b1) n_last++;
         last_addr = rd_add_in;
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL read_extra: got in=%0d k=%0d last=%0b, expected no read",
                     rd_add_in, rd_add_k, last_tap);
         end else begin
            e = exp_q.pop_front();
            if (got !== e)
               $display("FAIL read_seq #%0d: got in=%0d k=%0d last=%0b, expected in=%0d k=%0d last=%0b",
                        n_reads - 1, got.a_in, got.a_k, got.last, e.a_in, e.a_k, e.last);
            else pass_cnt++;
         end
      end
      if (done === 1'b1) begin
         n_done++;
         done_cyc = cyc;
         total_cnt++;
         if (busy !== 1'b0) $display("FAIL busy_at_done: got %0b, expected 0", busy);
         else pass_cnt++;
      end
      if (cfg_err === 1'b1) n_cfgerr++;
   end

   task automatic clear_counts();
      n_reads  = 0;
      n_last   = 0;
      n_done   = 0;
      n_cfgerr = 0;
      exp_q.delete();
   endtask

   task automatic push_model(input int w, input int h, input int kw, input int kh);
      exp_t e;
      for (int oy = 0; oy <= h - kh; oy++)
         for (int ox = 0; ox <= w - kw; ox++)
            for (int ky = 0; ky < kh; ky++)
               for (int kx = 0; kx < kw; kx++) begin
                  e.a_in = 8'((oy + ky) * w + ox + kx);
                  e.a_k  = 6'(ky * kw + kx);
                  e.last = (kx == kw - 1) && (ky == kh - 1);
                  exp_q.push_back(e);
               end
   endtask

   task automatic do_start(input int w, input int h, input int kw, input int kh);
      @(posedge clk); #1;
      img_w = 8'(w); img_h = 8'(h); k_w = 4'(kw); k_h = 4'(kh);
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      for (int i = 0; i < budget && n_done == 0; i++) @(posedge clk);
      #1;
      if (n_done == 0) begin
         total_cnt++;
         $display("FAIL %s_timeout: got no done within %0d cycles, expected done", tag, budget);
      end
   endtask

   task automatic wait_reads(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && n_reads < n; i++) @(posedge clk);
      #1;
      if (n_reads < n) begin
         total_cnt++;
         $display("FAIL %s_read_timeout: got %0d reads, expected %0d", tag, n_reads, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({rd_en, rd_add_in, rd_add_k, last_tap, out_size, size_valid, busy, done, cfg_err} !== '0)
         $display("FAIL reset_outputs: got rd_en=%0b busy=%0b size=%0d in=%0d, expected all 0",
                  rd_en, busy, out_size, rd_add_in);
      else pass_cnt++;
      start = 1'b1; img_w = 8'd4; img_h = 8'd4; k_w = 4'd3; k_h = 4'd3;
      @(posedge clk); #1;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_start_ignored: got busy=%0b, expected 0", busy);
      else pass_cnt++;
      start = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({busy, rd_en} !== 2'b00) $display("FAIL idle_no_start: got busy=%0b rd_en=%0b, expected 0 0", busy, rd_en);
      else pass_cnt++;
   endtask

   task automatic test_basic_4x4();
      clear_counts();
      push_model(4, 4, 3, 3);
      do_start(4, 4, 3, 3);
      wait_done(200, "basic");
      total_cnt++;
      if (out_size !== 9'd4) $display("FAIL basic_out_size: got %0d, expected 4", out_size); else pass_cnt++;
      total_cnt++;
      if (size_valid !== 1'b1) $display("FAIL basic_size_valid: got %0b, expected 1", size_valid); else pass_cnt++;
      total_cnt++;
      if (n_reads != 36) $display("FAIL basic_reads: got %0d, expected 36", n_reads); else pass_cnt++;
      total_cnt++;
      if (n_last != 4) $display("FAIL basic_last_taps: got %0d, expected 4", n_last); else pass_cnt++;
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL basic_missing: got %0d reads short, expected 0", exp_q.size()); else pass_cnt++;
      total_cnt++;
      if (first_cyc - start_cyc != 2) $display("FAIL basic_latency: got %0d, expected 2", first_cyc - start_cyc); else pass_cnt++;
      total_cnt++;
      if (done_cyc - start_cyc != 38) $display("FAIL basic_done_cycle: got %0d, expected 38", done_cyc - start_cyc); else pass_cnt++;
      total_cnt++;
      if (last_addr != 8'd15) $display("FAIL basic_last_addr: got %0d, expected 15", last_addr); else pass_cnt++;
      total_cnt++;
      if (n_done != 1) $display("FAIL basic_done_count: got %0d, expected 1", n_done); else pass_cnt++;
   endtask

   task automatic test_1x1_16x16();
      clear_counts();
      push_model(16, 16, 1, 1);
      do_start(16, 16, 1, 1);
      wait_done(400, "k1x1");
      total_cnt++;
      if (out_size !== 9'd256) $display("FAIL k1x1_out_size: got %0d, expected 256", out_size); else pass_cnt++;
      total_cnt++;
      if (n_reads != 256) $display("FAIL k1x1_reads: got %0d, expected 256", n_reads); else pass_cnt++;
      total_cnt++;
      if (n_last != 256) $display("FAIL k1x1_last_taps: got %0d, expected 256", n_last); else pass_cnt++;
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL k1x1_missing: got %0d reads short, expected 0", exp_q.size()); else pass_cnt++;
      total_cnt++;
      if (last_addr != 8'd255) $display("FAIL k1x1_last_addr: got %0d, expected 255", last_addr); else pass_cnt++;
      total_cnt++;
      if (done_cyc - start_cyc != 258) $display("FAIL k1x1_done_cycle: got %0d, expected 258", done_cyc - start_cyc); else pass_cnt++;
   endtask

   task automatic test_stall();
      clear_counts();
      push_model(4, 4, 3, 3);
      do_start(4, 4, 3, 3);
      wait_reads(10, 100, "stall");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total_cnt++;
         if (rd_en !== 1'b0) $display("FAIL stall_rd_en: got %0b in stall cycle %0d, expected 0", rd_en, i);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      stall = 1'b0;
      wait_done(200, "stall");
      total_cnt++;
      if (n_reads != 36) $display("FAIL stall_reads: got %0d, expected 36", n_reads); else pass_cnt++;
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL stall_missing: got %0d reads short, expected 0", exp_q.size()); else pass_cnt++;
      total_cnt++;
      if (n_last != 4) $display("FAIL stall_last_taps: got %0d, expected 4", n_last); else pass_cnt++;
      total_cnt++;
      if (done_cyc - start_cyc != 41) $display("FAIL stall_done_cycle: got %0d, expected 41", done_cyc - start_cyc); else pass_cnt++;
   endtask

   task automatic test_cfg_err();
      clear_counts();
      do_start(4, 4, 5, 3);
      repeat (6) @(posedge clk);
      #1;
      total_cnt++;
      if (n_cfgerr != 1) $display("FAIL cfg_wide_err: got %0d pulses, expected 1", n_cfgerr); else pass_cnt++;
      total_cnt++;
      if (n_reads != 0) $display("FAIL cfg_wide_reads: got %0d, expected 0", n_reads); else pass_cnt++;
      total_cnt++;
      if (size_valid !== 1'b0) $display("FAIL cfg_wide_size_valid: got %0b, expected 0", size_valid); else pass_cnt++;
      total_cnt++;
      if ({busy, n_done != 0} !== 2'b00) $display("FAIL cfg_wide_idle: got busy=%0b done=%0d, expected 0 0", busy, n_done); else pass_cnt++;
      clear_counts();
      do_start(16, 16, 9, 9);
      repeat (6) @(posedge clk);
      #1;
      total_cnt++;
      if (n_cfgerr != 1) $display("FAIL cfg_k81_err: got %0d pulses, expected 1", n_cfgerr); else pass_cnt++;
      total_cnt++;
      if (n_reads != 0) $display("FAIL cfg_k81_reads: got %0d, expected 0", n_reads); else pass_cnt++;
      total_cnt++;
      if (size_valid !== 1'b0) $display("FAIL cfg_k81_size_valid: got %0b, expected 0", size_valid); else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      clear_counts();
      push_model(4, 4, 3, 3);
      do_start(4, 4, 3, 3);
      wait_reads(20, 100, "rstmid");
      total_cnt++;
      if ({busy, rd_en} !== 2'b11) $display("FAIL rstmid_running: got busy=%0b rd_en=%0b, expected 1 1", busy, rd_en);
      else pass_cnt++;
      rst = 1'b1;
      #1;
      total_cnt++;
      if ({rd_en, rd_add_in, rd_add_k, last_tap, out_size, size_valid, busy, done, cfg_err} !== '0)
         $display("FAIL rstmid_outputs: got rd_en=%0b busy=%0b size=%0d in=%0d, expected all 0",
                  rd_en, busy, out_size, rd_add_in);
      else pass_cnt++;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      total_cnt++;
      if (n_done != 0) $display("FAIL rstmid_no_done: got %0d done pulses, expected 0", n_done); else pass_cnt++;
      clear_counts();
      push_model(4, 4, 3, 3);
      do_start(4, 4, 3, 3);
      wait_done(200, "rstmid_rerun");
      total_cnt++;
      if (n_reads != 36) $display("FAIL rstmid_rerun_reads: got %0d, expected 36", n_reads); else pass_cnt++;
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL rstmid_rerun_missing: got %0d reads short, expected 0", exp_q.size()); else pass_cnt++;
      total_cnt++;
      if (done_cyc - start_cyc != 38) $display("FAIL rstmid_rerun_done: got %0d, expected 38", done_cyc - start_cyc); else pass_cnt++;
   endtask

   task automatic test_start_ignored();
      clear_counts();
      push_model(4, 4, 3, 3);
      do_start(4, 4, 3, 3);
      wait_reads(5, 100, "restart");
      img_w = 8'd8; img_h = 8'd8; k_w = 4'd2; k_h = 4'd2;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(200, "restart");
      total_cnt++;
      if (n_reads != 36) $display("FAIL restart_reads: got %0d, expected 36", n_reads); else pass_cnt++;
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL restart_missing: got %0d reads short, expected 0", exp_q.size()); else pass_cnt++;
      total_cnt++;
      if (out_size !== 9'd4) $display("FAIL restart_out_size: got %0d, expected 4", out_size); else pass_cnt++;
      total_cnt++;
      if (done_cyc - start_cyc != 38) $display("FAIL restart_done_cycle: got %0d, expected 38", done_cyc - start_cyc); else pass_cnt++;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if (n_done != 1 || busy !== 1'b0) $display("FAIL restart_single_run: got done=%0d busy=%0b, expected 1 0", n_done, busy);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic_4x4();
      test_1x1_16x16();
      test_stall();
      test_cfg_err();
      test_reset_mid_run();
      test_start_ignored();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected finish");
      $fatal(1);
   end

endmodule
